mem_arbiter: RTL and testbench

Two-master, single-port on-chip memory with round-robin arbitration. It sits directly downstream of the DMA engine and the core load/store path, and is the endpoint for their `mem_req`/`mem_gnt` request ports. It accepts one 64-bit read or write per cycle and returns read data one cycle after grant. It also flags out-of-range accesses and counts accepted transactions.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, single-port 64-bit memory with round-robin
// arbitration, one-cycle registered read return, out-of-range flagging
// and an accepted-transaction counter.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        master X request (X = 0 core, 1 DMA)
//   mX_gnt                      combinational grant, same cycle as accept
//   mX_rvalid/rdata             registered read return, cycle after grant
//   oob                         one-cycle pulse after an out-of-range grant
//   txn_count                   accepted-transaction counter, wraps
module mem_arbiter #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [63:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [63:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [63:0] m1_rdata,
    output logic        oob,
    output logic [15:0] txn_count
);

    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } last_e;

    last_e       r_last;
    logic        r_m0_rvalid;
    logic        r_m1_rvalid;
    logic [63:0] r_m0_rdata;
    logic [63:0] r_m1_rdata;
    logic        r_oob;
    logic [15:0] r_txn_count;
    logic [63:0] r_mem [DEPTH];

    logic          w_m0_gnt;
    logic          w_m1_gnt;
    logic          w_gnt_any;
    logic          w_we;
    logic [63:0]   w_addr;
    logic [63:0]   w_wdata;
    logic [AW-1:0] w_idx;
    logic          w_oob;
    logic [63:0]   w_rd;
    logic [2:0]    w_unused_addr_lsbs;

    // On a tie the master that was not granted last wins.
    always_comb begin
        w_m0_gnt = m0_req & (~m1_req | (r_last == LAST_M1));
        w_m1_gnt = m1_req & (~m0_req | (r_last == LAST_M0));
        w_gnt_any = w_m0_gnt | w_m1_gnt;
        if (w_m1_gnt) begin
            w_we    = m1_we;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
        end else begin
            w_we    = m0_we;
            w_addr  = m0_addr;
            w_wdata = m0_wdata;
        end
        w_idx              = w_addr[AW+2:3];
        w_oob              = |w_addr[63:AW+3];
        w_unused_addr_lsbs = w_addr[2:0];
        w_rd               = w_oob ? '0 : r_mem[w_idx];
    end

    // Storage has no reset so that reset never disturbs stored words.
    always_ff @(posedge clk) begin
        if (w_gnt_any && w_we && !w_oob) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= LAST_M1;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_oob       <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_m0_rvalid <= w_m0_gnt & ~w_we;
            r_m1_rvalid <= w_m1_gnt & ~w_we;
            if (w_m0_gnt && !w_we) begin
                r_m0_rdata <= w_rd;
            end
            if (w_m1_gnt && !w_we) begin
                r_m1_rdata <= w_rd;
            end
            r_oob <= w_gnt_any & w_oob;
            if (w_gnt_any) begin
                r_txn_count <= r_txn_count + 16'd1;
            end
            if (w_m0_gnt) begin
                r_last <= LAST_M0;
            end else if (w_m1_gnt) begin
                r_last <= LAST_M1;
            end
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign oob       = r_oob;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Two instances share all inputs: u_dut (DEPTH=256) and u_big (DEPTH=1024,
// used where the addresses exceed the 256-word range).
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, oob;
    logic [63:0] m0_rdata, m1_rdata;
    logic [15:0] txn_count;

    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_oob;
    logic [63:0] b_m0_rdata, b_m1_rdata;
    logic [15:0] b_txn_count;

    int checks   = 0;
    int failures = 0;
    int g0, g1;

    mem_arbiter #(.DEPTH(256)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .oob(oob), .txn_count(txn_count)
    );

    mem_arbiter #(.DEPTH(1024)) u_big (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .oob(b_oob), .txn_count(b_txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

        // Reset state
        #12;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_oob", oob, 0);
        chk("rst_txn", txn_count, 0);
        m0_req = 1; m1_req = 1;
        #1;
        chk("rst_tie_m0_gnt", m0_gnt, 1);
        chk("rst_tie_m1_gnt", m1_gnt, 0);
        m0_req = 0; m1_req = 0;
        cyc();
        rst_n = 1'b1;

        // Single write (m1) then read (m0), then read by m1
        m1_req = 1; m1_we = 1; m1_addr = 64'h18; m1_wdata = 64'hDEAD0003;
        #1;
        chk("wr_m1_gnt", m1_gnt, 1);
        chk("wr_m0_gnt", m0_gnt, 0);
        cyc();
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 64'h18;
        #1;
        chk("rd_m0_gnt", m0_gnt, 1);
        chk("rd_m1_rvalid_after_wr", m1_rvalid, 0);
        chk("rd_m0_rvalid_early", m0_rvalid, 0);
        cyc();
        m0_req = 0;
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 64'hDEAD0003);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        chk("rd_txn", txn_count, 2);
        m1_req = 1; m1_we = 0; m1_addr = 64'h1F;
        #1;
        chk("rd2_m1_gnt", m1_gnt, 1);
        cyc();
        m1_req = 0;
        chk("rd2_m1_rvalid", m1_rvalid, 1);
        chk("rd2_m1_rdata", m1_rdata, 64'hDEAD0003);
        chk("rd2_m0_rvalid", m0_rvalid, 0);
        chk("rd2_m0_rdata_hold", m0_rdata, 64'hDEAD0003);
        chk("rd2_txn", txn_count, 3);

        // Contention: both write every cycle for 10 cycles
        g0 = 0; g1 = 0;
        for (int i = 0; i < 10; i++) begin
            m0_req = 1; m0_we = 1; m0_addr = 64'h40; m0_wdata = 64'hA0 + 64'(i);
            m1_req = 1; m1_we = 1; m1_addr = 64'h48; m1_wdata = 64'hB0 + 64'(i);
            #1;
            chk("cont_m0_gnt", m0_gnt, (i % 2 == 0) ? 1 : 0);
            chk("cont_m1_gnt", m1_gnt, (i % 2 == 1) ? 1 : 0);
            if (m0_gnt) g0++;
            if (m1_gnt) g1++;
            cyc();
        end
        m0_req = 0; m1_req = 0;
        chk("cont_g0", 64'(g0), 5);
        chk("cont_g1", 64'(g1), 5);
        chk("cont_txn", txn_count, 13);

        // Burst on the 1024-word instance: 10 writes then 10 reads
        for (int k = 0; k < 10; k++) begin
            m1_req = 1; m1_we = 1; m1_addr = 64'h1000 + 64'(8 * k);
            m1_wdata = 64'hDEAD0000 + 64'(k);
            #1;
            chk("burst_wr_gnt", b_m1_gnt, 1);
            cyc();
        end
        for (int k = 0; k < 10; k++) begin
            m1_req = 1; m1_we = 0; m1_addr = 64'h1000 + 64'(8 * k);
            cyc();
            chk("burst_rvalid", b_m1_rvalid, 1);
            chk("burst_rdata", b_m1_rdata, 64'hDEAD0000 + 64'(k));
        end
        m1_req = 0;
        chk("burst_txn", txn_count, 33);
        chk("burst_big_txn", b_txn_count, 33);
        cyc();
        chk("burst_rvalid_end", b_m1_rvalid, 0);

        // Out-of-range on the 256-word instance
        m0_req = 1; m0_we = 1; m0_addr = 64'h0; m0_wdata = 64'h1234;
        #1;
        chk("oob_w0_gnt", m0_gnt, 1);
        cyc();
        m0_addr = 64'h800; m0_wdata = 64'h55;
        #1;
        chk("oob_wr_gnt", m0_gnt, 1);
        chk("oob_pre", oob, 0);
        cyc();
        chk("oob_wr_pulse", oob, 1);
        m0_we = 0; m0_addr = 64'h800;
        #1;
        chk("oob_rd_gnt", m0_gnt, 1);
        cyc();
        chk("oob_rd_pulse", oob, 1);
        chk("oob_rd_rvalid", m0_rvalid, 1);
        chk("oob_rd_rdata", m0_rdata, 0);
        m0_addr = 64'h0;
        cyc();
        m0_req = 0;
        chk("oob_alias_oob", oob, 0);
        chk("oob_alias_rvalid", m0_rvalid, 1);
        chk("oob_alias_rdata", m0_rdata, 64'h1234);
        chk("oob_txn", txn_count, 37);

        // Reset in the middle of a read return cycle
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 64'h18;
        #1;
        chk("mr_gnt", m0_gnt, 1);
        cyc();
        m0_req = 0;
        chk("mr_rvalid_pre", m0_rvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid_killed", m0_rvalid, 0);
        chk("mr_txn", txn_count, 0);
        m0_req = 1; m1_req = 1;
        #1;
        chk("mr_tie_m0_gnt", m0_gnt, 1);
        chk("mr_tie_m1_gnt", m1_gnt, 0);
        cyc();
        rst_n = 1'b1;
        m0_we = 0; m0_addr = 64'h40;
        m1_we = 0; m1_addr = 64'h18;
        #1;
        chk("mr_post_m0_gnt", m0_gnt, 1);
        chk("mr_post_m1_gnt", m1_gnt, 0);
        cyc();
        chk("mr_post_m0_rvalid", m0_rvalid, 1);
        chk("mr_post_m0_rdata", m0_rdata, 64'hA8);
        #1;
        chk("mr_next_m1_gnt", m1_gnt, 1);
        chk("mr_next_m0_gnt", m0_gnt, 0);
        cyc();
        m0_req = 0; m1_req = 0;
        chk("mr_next_m1_rvalid", m1_rvalid, 1);
        chk("mr_next_m1_rdata", m1_rdata, 64'hDEAD0003);
        chk("mr_next_txn", txn_count, 2);

        // Counter wrap: 65537 grants from reset
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 64'h0;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", txn_count, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        m0_req = 0;
        chk("wrap_one", txn_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
